fpga_rx_sched: RTL

Master-side scheduler for the 3×4-bit serial receive engine. Arbitrates receive requests from `N_REQ` clients (round-robin), sequences the receiver with `start_rx`, generates its `sync_rx` bit strobes, waits for `ready_rx`, and captures the 12-bit result. It then issues the release strobe that returns the receiver to its wait state. It sits between the request logic and the receiver instance.

---
 rtl/fpga_rx_sched_pkg.sv | 18 +
 rtl/fpga_rx_sched_tick.sv | 28 ++
 rtl/fpga_rx_sched.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fpga_rx_sched_pkg.sv
// Shared types and constants for the serial receive scheduler.
package fpga_rx_sched_pkg;

  localparam int unsigned RX_WORDS      = 3;
  localparam int unsigned RX_WORD_BITS  = 4;
  localparam int unsigned RX_TOTAL_BITS = RX_WORDS * RX_WORD_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SETTLE,
    S_SHIFT,
    S_WAIT_RDY,
    S_RELEASE,
    S_FIN
  } state_t;

endpackage

// File: rtl/fpga_rx_sched_tick.sv
// Free-running DIV divider with synchronous clear; tick_c marks the last cycle of each period.
module rx_sched_tick #(
  parameter int unsigned DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned DW = $clog2(DIV);

  logic [DW-1:0] cnt;

  // Period counter, wraps at DIV-1 and restarts from zero on clear
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == DW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end

  assign tick_c = !clear && (cnt == DW'(DIV - 1));

endmodule

// File: rtl/fpga_rx_sched.sv
// Round-robin scheduler that sequences the 3x4-bit serial receiver.
// Optional feature: define RX_SCHED_TIMEOUT_EN to enable the WAIT_RDY timeout
// (rx_rst pulse, done with err=1); otherwise WAIT_RDY waits forever.
module fpga_rx_sched
  import fpga_rx_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned DIV     = 8,
  parameter int unsigned TO_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic                     done,
  output logic                     err,
  output logic [RX_TOTAL_BITS-1:0] data_out,
  output logic                     start_rx,
  output logic                     sync_rx,
  output logic                     rx_rst,
  input  logic                     ready_rx,
  input  logic [RX_WORD_BITS-1:0]  word1,
  input  logic [RX_WORD_BITS-1:0]  word2,
  input  logic [RX_WORD_BITS-1:0]  word3
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = ($clog2(TO_BITS + 1) > 4) ? $clog2(TO_BITS + 1) : 4;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [IDX_W-1:0]         owner, owner_nxt;
  logic [IDX_W-1:0]         ptr, ptr_nxt;
  logic [N_REQ-1:0]         grant_nxt;
  logic [RX_TOTAL_BITS-1:0] data_nxt;
  logic                     start_nxt, sync_nxt, done_nxt;
`ifdef RX_SCHED_TIMEOUT_EN
  logic                     err_nxt, rx_rst_nxt;
`endif

  logic                     pick_vld;
  logic [IDX_W-1:0]         pick_idx;
  int unsigned              slot;
  logic                     tick_c;
  logic                     tick_clr_c;

  // Divider runs only while strobing or timing the ready wait
  assign tick_clr_c = !((state == S_SHIFT) || (state == S_WAIT_RDY));

  rx_sched_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (tick_clr_c),
    .tick_c (tick_c)
  );

  // Round-robin pick: first requester at or after the priority pointer
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    slot     = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      slot = 32'(ptr) + 32'(i);
      if (slot >= N_REQ) begin
        slot = slot - N_REQ;
      end
      if (req[IDX_W'(slot)]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(slot);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    owner_nxt  = owner;
    ptr_nxt    = ptr;
    grant_nxt  = grant;
    data_nxt   = data_out;
    start_nxt  = 1'b0;
    sync_nxt   = 1'b0;
    done_nxt   = 1'b0;
`ifdef RX_SCHED_TIMEOUT_EN
    err_nxt    = 1'b0;
    rx_rst_nxt = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          owner_nxt = pick_idx;
          grant_nxt = N_REQ'(1) << pick_idx;
          start_nxt = 1'b1;
          state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        cnt_nxt   = '0;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt == CNT_W'(1)) begin
          cnt_nxt   = '0;
          state_nxt = S_SHIFT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (tick_c) begin
          sync_nxt = 1'b1;
          if (cnt == CNT_W'(RX_TOTAL_BITS - 1)) begin
            cnt_nxt   = '0;
            state_nxt = S_WAIT_RDY;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_WAIT_RDY: begin
        // The 12th strobe is still on sync_rx in the first cycle here; ready is stale until it lands
        if (ready_rx && !sync_rx) begin
          data_nxt  = {word1, word2, word3};
          sync_nxt  = 1'b1;
          state_nxt = S_RELEASE;
        end
`ifdef RX_SCHED_TIMEOUT_EN
        else if (tick_c) begin
          if (cnt == CNT_W'(TO_BITS - 1)) begin
            rx_rst_nxt = 1'b1;
            err_nxt    = 1'b1;
            state_nxt  = S_FIN;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
`endif
      end
      S_RELEASE: begin
        state_nxt = S_FIN;
      end
      S_FIN: begin
        grant_nxt = '0;
        ptr_nxt   = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    done_nxt = (state_nxt == S_FIN);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      grant    <= '0;
      data_out <= '0;
      start_rx <= 1'b0;
      sync_rx  <= 1'b0;
      done     <= 1'b0;
`ifdef RX_SCHED_TIMEOUT_EN
      err      <= 1'b0;
      rx_rst   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      grant    <= grant_nxt;
      data_out <= data_nxt;
      start_rx <= start_nxt;
      sync_rx  <= sync_nxt;
      done     <= done_nxt;
`ifdef RX_SCHED_TIMEOUT_EN
      err      <= err_nxt;
      rx_rst   <= rx_rst_nxt;
`endif
    end
  end

`ifndef RX_SCHED_TIMEOUT_EN
  assign err    = 1'b0;
  assign rx_rst = 1'b0;
`endif

endmodule
